// File: rtl/psum_axis_master.sv
// AXI-Stream master for packed partial sums: a small FIFO feeding a registered output stage,
// with overflow, almost_full, layer_done and beat-count status.
module psum_axis_master #(
    parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH           = 16,
    parameter int unsigned AF_MARGIN            = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     in_data,
    input  logic                                in_last,
    input  logic                                clear_status,
    output logic                                M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic [(C_M_AXIS_TDATA_WIDTH/8)-1:0] M_AXIS_TSTRB,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY,
    output logic                                almost_full,
    output logic                                overflow,
    output logic                                layer_done,
    output logic [15:0]                         word_count
);

    localparam int unsigned DW = C_M_AXIS_TDATA_WIDTH;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] MARGIN_C = (AW+1)'(AF_MARGIN);

    logic [DW:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    occ_q, occ_d, mem_cnt, free_d;
    logic           out_valid_q, out_last_q;
    logic [DW-1:0]  out_data_q;
    logic           overflow_q, layer_done_q, almost_full_q;
    logic [15:0]    word_count_q;
    logic           pop, push, drop, full, load;

    assign full    = (occ_q == DEPTH_C);
    assign pop     = out_valid_q & M_AXIS_TREADY;
    assign push    = in_valid & (~full | pop);
    assign drop    = in_valid & full & ~pop;
    // Entries still in memory, excluding the one sitting in the output register.
    assign mem_cnt = occ_q - {{AW{1'b0}}, out_valid_q};
    assign load    = (mem_cnt != '0) & (~out_valid_q | pop);
    assign occ_d   = occ_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign free_d  = DEPTH_C - occ_d;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {in_last, in_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            occ_q         <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_data_q    <= '0;
            overflow_q    <= 1'b0;
            layer_done_q  <= 1'b0;
            almost_full_q <= 1'b0;
            word_count_q  <= '0;
        end else begin
            occ_q         <= occ_d;
            almost_full_q <= (free_d <= MARGIN_C);
            layer_done_q  <= pop & out_last_q;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (load) begin
                rd_ptr_q                 <= rd_ptr_q + 1'b1;
                out_valid_q              <= 1'b1;
                {out_last_q, out_data_q} <= mem[rd_ptr_q];
            end else if (pop) begin
                out_valid_q <= 1'b0;
            end
            // A fresh drop outranks a clear; a clear outranks a pop.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clear_status) begin
                overflow_q <= 1'b0;
            end
            if (clear_status) begin
                word_count_q <= '0;
            end else if (pop) begin
                word_count_q <= word_count_q + 16'd1;
            end
        end
    end

    assign M_AXIS_TVALID = out_valid_q;
    assign M_AXIS_TDATA  = out_data_q;
    assign M_AXIS_TLAST  = out_last_q;
    assign M_AXIS_TSTRB  = '1;
    assign almost_full   = almost_full_q;
    assign overflow      = overflow_q;
    assign layer_done    = layer_done_q;
    assign word_count    = word_count_q;

endmodule

// File: tb/tb_psum_axis_master.sv
// Scoreboard bench for psum_axis_master: directed stimulus queues expected beats, a negedge
// monitor compares every beat the DUT hands over.
module tb_psum_axis_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        clear_status = 1'b0;
    logic        tvalid, tlast, tready = 1'b0;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        almost_full, overflow, layer_done;
    logic [15:0] word_count;

    logic [32:0] sb [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    psum_axis_master #(
        .C_M_AXIS_TDATA_WIDTH(32),
        .FIFO_DEPTH          (16),
        .AF_MARGIN           (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .clear_status (clear_status),
        .M_AXIS_TVALID(tvalid),
        .M_AXIS_TDATA (tdata),
        .M_AXIS_TSTRB (tstrb),
        .M_AXIS_TLAST (tlast),
        .M_AXIS_TREADY(tready),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .layer_done   (layer_done),
        .word_count   (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic l, input bit expect_accept);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        if (expect_accept) sb.push_back({l, d});
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        tick();
        check("drain_complete", 64'(sb.size()), 64'd0);
    endtask

    // A handshake seen mid-cycle completes at the following rising edge.
    always @(negedge clk) begin
        if (!rst && tvalid && tready) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", {31'd0, tlast, tdata}, 64'h1_FFFF_FFFF);
            end else begin
                check("beat", {31'd0, tlast, tdata}, {31'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        tick();
        tick();
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tdata", 64'(tdata), 64'd0);
        check("rst_tlast", 64'(tlast), 64'd0);
        check("rst_af", 64'(almost_full), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_done", 64'(layer_done), 64'd0);
        check("rst_wc", 64'(word_count), 64'd0);
        check("tstrb", 64'(tstrb), 64'hF);
        rst = 1'b0;

        // Single beat with TLAST
        tready = 1'b1;
        push(32'hA5A5_0001, 1'b1, 1'b1);
        check("lat_tvalid_low", 64'(tvalid), 64'd0);
        tick();
        check("lat_tvalid_high", 64'(tvalid), 64'd1);
        check("lat_tlast", 64'(tlast), 64'd1);
        tick();
        check("layer_done_pulse", 64'(layer_done), 64'd1);
        check("wc_single", 64'(word_count), 64'd1);
        tick();
        check("layer_done_once", 64'(layer_done), 64'd0);

        // Backpressure
        tready = 1'b0;
        for (int i = 1; i <= 5; i++) push(32'(i), 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check("bp_tvalid", 64'(tvalid), 64'd1);
            check("bp_tdata", 64'(tdata), 64'd1);
            tick();
        end
        tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("b2b_tvalid", 64'(tvalid), 64'd1);
            tick();
        end
        check("b2b_idle", 64'(tvalid), 64'd0);
        check("hold_last_tdata", 64'(tdata), 64'd5);
        check("wc_bp", 64'(word_count), 64'd6);

        // Fill to full, drop the 17th beat
        tready = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            push(32'h100 + 32'(i), 1'b0, i <= 16);
            if (i == 11) check("af_at_11", 64'(almost_full), 64'd0);
            if (i == 12) check("af_at_12", 64'(almost_full), 64'd1);
        end
        check("ovf_after_drop", 64'(overflow), 64'd1);
        tready = 1'b1;
        wait_empty(40);
        check("wc_full", 64'(word_count), 64'd22);
        check("af_drained", 64'(almost_full), 64'd0);

        // Push into full with a simultaneous pop
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        check("clr_ovf", 64'(overflow), 64'd0);
        check("clr_wc", 64'(word_count), 64'd0);
        tready = 1'b0;
        for (int i = 1; i <= 16; i++) push(32'h200 + 32'(i), 1'b0, 1'b1);
        tready = 1'b1;
        push(32'h2FF, 1'b0, 1'b1);
        tready = 1'b0;
        check("full_pop_ovf", 64'(overflow), 64'd0);
        check("full_pop_af", 64'(almost_full), 64'd1);
        push(32'hDEAD, 1'b0, 1'b0);
        check("still_full_drop", 64'(overflow), 64'd1);
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        tready = 1'b1;
        wait_empty(40);
        check("wc_full_pop", 64'(word_count), 64'd16);

        // word_count wrap
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            in_data = 32'(i);
            sb.push_back({1'b0, 32'(i)});
            tick();
        end
        in_valid = 1'b0;
        wait_empty(40);
        check("wc_ffff", 64'(word_count), 64'hFFFF);
        push(32'h5555_0000, 1'b0, 1'b1);
        wait_empty(10);
        check("wc_wrap", 64'(word_count), 64'd0);
        push(32'h5555_0001, 1'b1, 1'b1);
        wait_empty(10);
        check("wc_one", 64'(word_count), 64'd1);

        // Clear coinciding with a drop, then with a pop
        tready = 1'b0;
        for (int i = 1; i <= 16; i++) push(32'h400 + 32'(i), 1'b0, 1'b1);
        clear_status = 1'b1;
        push(32'hBAD0, 1'b0, 1'b0);
        clear_status = 1'b0;
        check("clr_drop_ovf", 64'(overflow), 64'd1);
        check("clr_drop_wc", 64'(word_count), 64'd0);
        tready = 1'b1;
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        check("clr_pop_wc", 64'(word_count), 64'd0);
        check("clr_pop_ovf", 64'(overflow), 64'd0);
        wait_empty(40);
        check("wc_after_clr_pop", 64'(word_count), 64'd15);

        // Asynchronous reset mid-transfer
        tready = 1'b0;
        for (int i = 1; i <= 3; i++) push(32'h300 + 32'(i), 1'b0, 1'b1);
        for (int i = 0; i < 5 && !tvalid; i++) tick();
        check("pre_rst_tvalid", 64'(tvalid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_tvalid", 64'(tvalid), 64'd0);
        check("async_tdata", 64'(tdata), 64'd0);
        check("async_wc", 64'(word_count), 64'd0);
        sb.delete();
        tick();
        rst = 1'b0;
        tready = 1'b1;
        for (int i = 1; i <= 3; i++) push(32'h310 + 32'(i), i == 3, 1'b1);
        wait_empty(20);
        check("wc_post_rst", 64'(word_count), 64'd3);
        check("final_idle", 64'(tvalid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
